// File: rtl/osc_freq_meter.sv
// Multi-channel oscillator frequency meter: counts synchronised rising edges of one
// selected input over a fixed gate window and hands the result out via valid/ready.
//
// state  | meaning
// IDLE   | waiting for start_i or scan_i
// SETTLE | one cycle to seed the edge detector from the newly latched channel
// GATE   | counting edges for GATE_CYCLES cycles
// HOLD   | result presented, waiting for ready_i
module osc_freq_meter #(
    parameter int N_CH        = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int GATE_CYCLES = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    scan_i,
    input  logic                    start_i,
    input  logic [$clog2(N_CH)-1:0] ch_sel_i,
    input  logic [N_CH-1:0]         osc_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [CNT_WIDTH-1:0]    count_o,
    output logic [$clog2(N_CH)-1:0] ch_o,
    output logic                    overflow_o,
    output logic                    busy_o
);

    localparam int CH_W = $clog2(N_CH);
    localparam int TW   = $clog2(GATE_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] GATE   = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]           state_q;
    logic [N_CH-1:0]      sync_q [SYNC_STAGES];
    logic [CH_W-1:0]      ch_q;
    logic [CH_W-1:0]      scan_ptr_q;
    logic [TW-1:0]        timer_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 ovf_q;
    logic                 ovf_next;
    logic                 prev_q;
    logic                 sel_bit;
    logic                 edge_det;

    // Every input is synchronised all the time so a channel switch sees settled data.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= osc_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sel_bit  = sync_q[SYNC_STAGES-1][ch_q];
    assign edge_det = sel_bit & ~prev_q;
    assign busy_o   = (state_q != IDLE);

    // Saturating count: once all-ones, further edges only flag overflow.
    always_comb begin
        cnt_next = cnt_q;
        ovf_next = ovf_q;
        if (edge_det) begin
            if (&cnt_q) ovf_next = 1'b1;
            else        cnt_next = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            scan_ptr_q <= '0;
            timer_q    <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            prev_q     <= 1'b0;
            valid_o    <= 1'b0;
            count_o    <= '0;
            ch_o       <= '0;
            overflow_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i && (scan_i || start_i)) begin
                        ch_q    <= scan_i ? scan_ptr_q : ch_sel_i;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else begin
                        prev_q  <= sel_bit;
                        timer_q <= TW'(GATE_CYCLES - 1);
                        state_q <= GATE;
                    end
                end
                GATE: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else begin
                        prev_q <= sel_bit;
                        cnt_q  <= cnt_next;
                        ovf_q  <= ovf_next;
                        if (timer_q == '0) begin
                            count_o    <= cnt_next;
                            ch_o       <= ch_q;
                            overflow_o <= ovf_next;
                            valid_o    <= 1'b1;
                            state_q    <= HOLD;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state_q <= IDLE;
                        if (scan_ptr_q == CH_W'(N_CH - 1)) scan_ptr_q <= '0;
                        else                               scan_ptr_q <= scan_ptr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
